// File: rtl/sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : sram_resp
// Brief    : Single-port word memory behind AXI4-Lite-style read/write
//            channels with a fixed response latency and one outstanding op.
// Revision : 1.0 - initial release
// ============================================================================
module sram_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  C_LAT_M1 = 4'(LATENCY - 1);
    localparam logic [32:0] C_SPAN   = 33'd4 << DEPTH_LOG2;
    localparam logic [1:0]  C_OKAY   = 2'b00;
    localparam logic [1:0]  C_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [1:0]  bresp_q;
    logic [31:0] mem_q [DEPTH];

    logic                  w_idle;
    logic                  w_rd_hs;
    logic                  w_wr_hs;
    logic                  w_load_rd;
    logic                  w_commit;
    logic [31:0]           w_addr;
    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;

    assign w_idle  = (state_q == IDLE);
    assign arready = rst & w_idle;
    assign awready = rst & w_idle & ~arvalid & awvalid & wvalid;
    assign wready  = awready;
    assign w_rd_hs = arvalid & arready;
    assign w_wr_hs = awready;

    // With LATENCY=1 the array is touched straight from IDLE, so the live
    // request fields are used there instead of the latched copies.
    assign w_addr  = w_idle ? (arvalid ? araddr : awaddr) : addr_q;
    assign w_wdata = w_idle ? wdata : wdata_q;
    assign w_wstrb = w_idle ? wstrb : wstrb_q;

    // An underflowing subtraction is rejected by the >= BASE_ADDR term.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) && ({1'b0, w_off} < C_SPAN);
    assign w_idx      = w_off[DEPTH_LOG2+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_load_rd = 1'b0;
        w_commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_rd_hs) begin
                    if (LATENCY == 1) begin
                        state_d   = RD_RESP;
                        w_load_rd = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = C_LAT_M1;
                    end
                end else if (w_wr_hs) begin
                    if (LATENCY == 1) begin
                        state_d  = WR_RESP;
                        w_commit = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                        cnt_d   = C_LAT_M1;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d   = RD_RESP;
                    cnt_d     = 4'd0;
                    w_load_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (rready) state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d  = WR_RESP;
                    cnt_d    = 4'd0;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_RESP: begin
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            w_load_rd = 1'b0;
            w_commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (!rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            rresp_q <= C_OKAY;
            bresp_q <= C_OKAY;
        end else begin
            if (w_rd_hs || w_wr_hs) begin
                addr_q  <= w_addr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_load_rd) begin
                rdata_q <= w_in_range ? mem_q[w_idx] : 32'd0;
                rresp_q <= w_in_range ? C_OKAY : C_DECERR;
            end
            if (w_commit) begin
                bresp_q <= w_in_range ? C_OKAY : C_DECERR;
            end
        end
    end

    // Array has no reset; w_commit is already suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (w_commit && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign rvalid = (state_q == RD_RESP);
    assign bvalid = (state_q == WR_RESP);
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign bresp  = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_resp
// Brief    : Directed self-checking bench for sram_resp (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = 32'd0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = 32'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    sram_resp #(
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("wr_awready", {31'd0, awready}, 32'd1);
        check("wr_wready", {31'd0, wready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid_t1", {31'd0, bvalid}, 32'd0);
        tick();
        check("wr_bvalid_t2", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        #1;
        check("wr_bvalid_done", {31'd0, bvalid}, 32'd0);
        check("wr_bresp_hold", {30'd0, bresp}, {30'd0, exp_resp});
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        araddr = a; arvalid = 1'b1;
        #1;
        check("rd_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("rd_rvalid_t1", {31'd0, rvalid}, 32'd0);
        tick();
        check("rd_rvalid_t2", {31'd0, rvalid}, 32'd1);
        check("rd_rdata", rdata, exp_data);
        check("rd_rresp", {30'd0, rresp}, {30'd0, exp_resp});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        #1;
        check("rd_rvalid_done", {31'd0, rvalid}, 32'd0);
        check("rd_arready_done", {31'd0, arready}, 32'd1);
        check("rd_rdata_hold", rdata, exp_data);
    endtask

    initial begin
        // Reset held with a pending read request
        rst = 1'b0; arvalid = 1'b1; araddr = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_arready", {31'd0, arready}, 32'd0);
            check("rst_rvalid", {31'd0, rvalid}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        rst = 1'b1;
        #1;
        check("rel_arready", {31'd0, arready}, 32'd1);
        arvalid = 1'b0;
        tick();

        // A lone awvalid or wvalid is not accepted
        awvalid = 1'b1; wvalid = 1'b0;
        #1;
        check("lone_aw", {31'd0, awready}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b1;
        #1;
        check("lone_w", {31'd0, wready}, 32'd0);
        wvalid = 1'b0;
        tick();

        // Full write then readback
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // Byte strobe merge; low address bits ignored
        do_write(32'h8000_0010, 32'h0000_5500, 4'b0010, 2'b00);
        do_read(32'h8000_0010, 32'hDEAD_55EF, 2'b00);
        do_read(32'h8000_0013, 32'hDEAD_55EF, 2'b00);

        // Zero strobe is a no-op with OKAY
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        do_read(32'h8000_0010, 32'hDEAD_55EF, 2'b00);

        // Backpressure on the read response
        araddr = 32'h8000_0010; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        check("bp_rvalid0", {31'd0, rvalid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata", rdata, 32'hDEAD_55EF);
            check("bp_arready", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        #1;
        check("bp_rvalid_done", {31'd0, rvalid}, 32'd0);
        check("bp_arready_done", {31'd0, arready}, 32'd1);

        // Decode errors and array boundaries
        do_write(32'h8000_0000, 32'h1234_5678, 4'b1111, 2'b00);
        do_write(32'h8000_0FFC, 32'hA5A5_0FFC, 4'b1111, 2'b00);
        do_read(32'h7FFF_FFFC, 32'd0, 2'b11);
        do_read(32'h8000_1000, 32'd0, 2'b11);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 2'b11);
        do_read(32'h8000_0000, 32'h1234_5678, 2'b00);
        do_read(32'h8000_0FFC, 32'hA5A5_0FFC, 2'b00);

        // Simultaneous read and write: read wins
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("arb_arready", {31'd0, arready}, 32'd1);
        check("arb_awready", {31'd0, awready}, 32'd0);
        tick();
        arvalid = 1'b0;
        check("arb_aw_wait", {31'd0, awready}, 32'd0);
        tick();
        check("arb_rvalid", {31'd0, rvalid}, 32'd1);
        check("arb_rdata", rdata, 32'hDEAD_55EF);
        check("arb_aw_resp", {31'd0, awready}, 32'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        #1;
        check("arb_aw_go", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("arb_bvalid_t1", {31'd0, bvalid}, 32'd0);
        tick();
        check("arb_bvalid_t2", {31'd0, bvalid}, 32'd1);
        check("arb_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h8000_0020, 32'hCAFE_F00D, 2'b00);

        // Reset during WR_WAIT drops the write
        awaddr = 32'h8000_0020; wdata = 32'h1111_1111; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b0;
        tick();
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_arready", {31'd0, arready}, 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rel_bvalid", {31'd0, bvalid}, 32'd0);
        do_read(32'h8000_0020, 32'hCAFE_F00D, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
